// File: rtl/multiword_add_seq_if.sv
// Valid/ready operand and result bundle for multiword_add_seq.
// Carries op_sub only when MWADD_SUB_EN is defined.
interface multiword_add_seq_if #(
  parameter int WIDTH  = 8,
  parameter int CHUNKS = 4
);
  localparam int TOTAL = WIDTH * CHUNKS;

  logic             in_valid;
  logic             in_ready;
  logic [TOTAL-1:0] a;
  logic [TOTAL-1:0] b;
  logic             cin;
`ifdef MWADD_SUB_EN
  logic             op_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [TOTAL-1:0] sum;
  logic             cout;
  logic             busy;

`ifdef MWADD_SUB_EN
  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
`endif
endinterface

// File: rtl/multiword_add_seq.sv
// Wide adder that time-shares one WIDTH-bit ripple-carry adder over CHUNKS cycles, LSB chunk first.
// Optional feature macro: MWADD_SUB_EN (adds op_sub for a-b via inverted B and carry-in 1).
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one chunk added per cycle, carry registered between chunks
// DONE  | result held with out_valid high until out_ready

module RippleCarryAdder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  logic [WIDTH:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = cin_i;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = carry[WIDTH];
endmodule

module multiword_add_seq #(
  parameter int WIDTH  = 8,
  parameter int CHUNKS = 4
) (
  input  logic               clk,
  input  logic               rst,
  multiword_add_seq_if.slave bus
);
  localparam int TOTAL = WIDTH * CHUNKS;
  localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TOTAL-1:0] a_q, a_d;
  logic [TOTAL-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [TOTAL-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef MWADD_SUB_EN
  logic             sub_q, sub_d;
`endif

  logic [WIDTH-1:0] chunk_a;
  logic [WIDTH-1:0] chunk_b;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic             last_chunk;

  // Chunk select as an explicit mux keeps the shared adder's operands narrow.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < CHUNKS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        chunk_a = a_q[i*WIDTH +: WIDTH];
        chunk_b = b_q[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MWADD_SUB_EN
  assign add_b = sub_q ? ~chunk_b : chunk_b;
`else
  assign add_b = chunk_b;
`endif

  RippleCarryAdder #(.WIDTH(WIDTH)) u_adder (
    .a_i    (chunk_a),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign last_chunk = (idx_q == IDX_W'(CHUNKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef MWADD_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef MWADD_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef MWADD_SUB_EN
    sub_d   = sub_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          idx_d   = '0;
          state_d = RUN;
`ifdef MWADD_SUB_EN
          sub_d   = bus.op_sub;
          carry_d = bus.op_sub ? 1'b1 : bus.cin;
`else
          carry_d = bus.cin;
`endif
        end
      end
      RUN: begin
        for (int i = 0; i < CHUNKS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*WIDTH +: WIDTH] = add_sum;
          end
        end
        carry_d = add_cout;
        if (last_chunk) begin
          cout_d  = add_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
Multi-cycle sequencer that adds two wide operands (WIDTH*CHUNKS bits) by time-sharing one narrow adder, one WIDTH-bit chunk per cycle, LSB chunk first. The adder is a single RippleCarryAdder #(.WIDTH(WIDTH)) instance. The carry is registered between chunks. Sits between a valid/ready producer and consumer in the arithmetic datapath. It trades latency for area on wide adds.

Parameters:
WIDTH, 8, chunk width = width of the shared adder instance
CHUNKS, 4, number of chunks per operand (>=1); TOTAL = WIDTH*CHUNKS (derived localparam)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  TOTAL  operand A, sampled on accept
b  input  TOTAL  operand B, sampled on accept
cin  input  1  carry-in, sampled on accept
out_valid  output  1  result valid (high only in DONE)
out_ready  input  1  consumer accepts result
sum  output  TOTAL  result, registered
cout  output  1  final carry-out, registered
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE, idx=0, carry_reg=0, sum=0, cout=0, out_valid=0, busy=0. in_ready=1 after reset.
- Reset mid-operation (RUN or DONE) aborts the operation. No out_valid pulse occurs, partial results are discarded, and IDLE is entered next cycle.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_reg=a, b_reg=b, carry_reg=cin, idx=0, then go to RUN.
- RUN:
  - Adder inputs: a_reg[idx*WIDTH +: WIDTH], b_reg[same], carry_reg.
  - Each edge: sum[idx chunk] <= adder sum, carry_reg <= adder cout, idx <= idx+1.
  - When idx==CHUNKS-1: also cout <= adder cout, then go to DONE.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1.
  - sum and cout are held stable until out_ready=1.
  - On out_valid&&out_ready: go to IDLE, out_valid drops next cycle.
- Latency: out_valid is asserted exactly CHUNKS cycles after the accepting edge.
  - No bypass: a new accept is possible only the cycle after result handoff.
  - Min initiation interval = CHUNKS+2 cycles.
- Arithmetic: result is modulo 2^TOTAL; cout is the true carry out of bit TOTAL-1.
- sum content outside DONE: previous result is partially overwritten during RUN and must not be used. Consumers qualify sum with out_valid.
- CHUNKS=1: RUN lasts one cycle, latency 1.
- idx width = clog2(CHUNKS), minimum 1 bit; no wrap beyond CHUNKS-1.

Optional Feature:
MWADD_SUB_EN
- Defined:
  - Adds input port op_sub (1 bit), sampled on accept.
  - op_sub=1: adder B input is the inverted b_reg chunk, carry_reg initialised to 1, cin ignored. Result = a-b mod 2^TOTAL; cout=1 means no borrow (a>=b unsigned).
  - op_sub=0: identical to add.
- Undefined: no op_sub port, add only, no inverter logic.

Test Plan:
1. WIDTH=8, CHUNKS=4, a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, out_valid exactly 4 cycles after accept edge.
2. a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1 (carry ripples through all chunk registers).
3. After result, hold out_ready=0 for 5 cycles while pulsing in_valid -> sum/cout/out_valid stable, in_ready=0, no new accept; out_ready=1 -> IDLE next cycle, in_ready=1.
4. rst pulsed during RUN after 2 chunks -> next cycle state IDLE, out_valid=0, busy=0, sum=0; following op a=0x12345678, b=0x11111111 -> 0x23456789, cout=0.
5. MWADD_SUB_EN: a=0x10, b=0x01, op_sub=1 -> sum=0x0000000F, cout=1; a=0, b=1, op_sub=1 -> sum=0xFFFFFFFF, cout=0.
6. CHUNKS=1 build: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, out_valid 1 cycle after accept.
